// File: rtl/uart_dbg_pkg.sv
// ============================================================================
//  Module   : uart_dbg_pkg
//  Purpose  : Shared definitions for the UART debug host: protocol byte
//             codes, command encoding, dump-kind encoding and the host FSM
//             state encoding.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_dbg_pkg;

    // Protocol byte codes understood by the pipeline's UART debug unit
    localparam logic [7:0] c_load_prog_size = 8'hFE;
    localparam logic [7:0] c_debug          = 8'hFC;
    localparam logic [7:0] c_next           = 8'h01;
    localparam logic [7:0] c_end_debug      = 8'hF8;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_STEP = 2'd1,
        CMD_END  = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        KIND_REG = 2'd0,
        KIND_MEM = 2'd1,
        KIND_PC  = 2'd2
    } dump_kind_e;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_TX_OP   = 4'd1,
        ST_TX_SIZE = 4'd2,
        ST_FETCH   = 4'd3,
        ST_TX_INST = 4'd4,
        ST_TX_DBG  = 4'd5,
        ST_TX_NEXT = 4'd6,
        ST_RX_DUMP = 4'd7,
        ST_TX_END  = 4'd8,
        ST_DONE    = 4'd9
    } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_word_packer.sv
// ============================================================================
//  Module   : uart_word_packer
//  Purpose  : Assembles a stream of bytes into 32-bit words, least
//             significant byte first. A word strobe is issued the cycle
//             after its fourth byte is accepted.
//  Ports    : i_clock, i_reset (async, active-high)
//             i_clear       - synchronous restart of byte counter/assembler
//             i_byte_valid  - i_byte is accepted this cycle
//             i_byte        - incoming byte
//             o_count       - bytes already held for the current word (0..3)
//             o_word_valid  - one-cycle strobe, o_word is a complete word
//             o_word        - last assembled word (held between strobes)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_word_packer (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_count,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [31:0] r_shift;
    logic [1:0]  r_count;
    logic        r_word_valid;
    logic [31:0] r_word;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_shift      <= '0;
            r_count      <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_shift <= '0;
                r_count <= '0;
            end else if (i_byte_valid) begin
                // New bytes enter at the top so the first byte ends up lowest
                r_shift <= {i_byte, r_shift[31:8]};
                r_count <= r_count + 2'd1;
                if (r_count == 2'd3) begin
                    r_word       <= {i_byte, r_shift[31:8]};
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_count      = r_count;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

`default_nettype wire

// File: rtl/uart_debug_host.sv
// ============================================================================
//  Module   : uart_debug_host
//  Purpose  : Host-side master for the pipeline UART debug interface.
//             Issues LOAD / STEP / END command byte sequences into a TX FIFO
//             and reassembles the returned state dump (register words,
//             data-memory words, PC) from an RX FIFO into 32-bit words.
//  Ports    : i_clock, i_reset (async, active-high)
//             command  : i_cmd_valid, i_cmd, o_cmd_ready
//             program  : i_prog_size, o_prog_addr, i_prog_data (sync read)
//             TX FIFO  : o_tx_data, o_wr, i_tx_full
//             RX FIFO  : i_rx_data, i_rx_empty, o_rd (first-word fall-through)
//             dump     : o_dump_valid, o_dump_kind, o_dump_idx, o_dump_word
//             status   : o_busy, o_done, o_in_debug, o_timeout
//  Options  : UART_DEBUG_HOST_TIMEOUT_EN - RX-idle watchdog of TO_CYC cycles
//             during dump reception; o_timeout tied low when undefined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_debug_host
    import uart_dbg_pkg::*;
#(
    parameter int N_REG  = 31,
    parameter int N_MEM  = 31,
    parameter int PSZ_W  = 8,
    parameter int TO_CYC = 1000000
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic [PSZ_W-1:0] i_prog_size,
    output logic [PSZ_W-1:0] o_prog_addr,
    input  logic [31:0]      i_prog_data,
    output logic [7:0]       o_tx_data,
    output logic             o_wr,
    input  logic             i_tx_full,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_empty,
    output logic             o_rd,
    output logic             o_dump_valid,
    output logic [1:0]       o_dump_kind,
    output logic [5:0]       o_dump_idx,
    output logic [31:0]      o_dump_word,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_in_debug,
    output logic             o_timeout
);

    state_e           r_state;
    state_e           w_next;
    logic             r_ready;
    logic             r_in_debug;
    logic             r_load_pending;
    logic [PSZ_W-1:0] r_size;
    logic [PSZ_W-1:0] r_addr;
    logic [1:0]       r_byte_cnt;
    dump_kind_e       r_kind;
    logic [5:0]       r_idx;

    logic             w_accept;
    logic [7:0]       w_tx_data;
    logic             w_wr;
    logic             w_rd;
    logic             w_last_byte;
    logic             w_to_hit;
    logic [1:0]       w_pack_cnt;
    logic             w_pack_valid;
    logic [31:0]      w_pack_word;

    assign w_accept = i_cmd_valid && r_ready && (r_state == ST_IDLE);

    // The final byte of the dump is the fourth byte of the PC word
    assign w_last_byte = (r_kind == KIND_PC) && (w_pack_cnt == 2'd3);

    always_comb begin
        w_next    = r_state;
        w_tx_data = 8'h00;
        w_wr      = 1'b0;
        w_rd      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (i_cmd)
                        CMD_LOAD: w_next = r_in_debug ? ST_TX_END : ST_TX_OP;
                        CMD_STEP: w_next = r_in_debug ? ST_TX_NEXT : ST_TX_DBG;
                        CMD_END:  w_next = r_in_debug ? ST_TX_END : ST_DONE;
                        default:  w_next = ST_IDLE;
                    endcase
                end
            end
            ST_TX_END: begin
                w_tx_data = c_end_debug;
                w_wr      = !i_tx_full;
                if (!i_tx_full) w_next = r_load_pending ? ST_TX_OP : ST_DONE;
            end
            ST_TX_OP: begin
                w_tx_data = c_load_prog_size;
                w_wr      = !i_tx_full;
                if (!i_tx_full) w_next = ST_TX_SIZE;
            end
            ST_TX_SIZE: begin
                w_tx_data = 8'(r_size);
                w_wr      = !i_tx_full;
                if (!i_tx_full) w_next = (r_size == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                // One cycle for the synchronous program memory to follow the address
                w_next = ST_TX_INST;
            end
            ST_TX_INST: begin
                w_tx_data = i_prog_data[{r_byte_cnt, 3'b000} +: 8];
                w_wr      = !i_tx_full;
                if (!i_tx_full && (r_byte_cnt == 2'd3))
                    w_next = (r_addr == r_size - PSZ_W'(1)) ? ST_DONE : ST_FETCH;
            end
            ST_TX_DBG: begin
                w_tx_data = c_debug;
                w_wr      = !i_tx_full;
                if (!i_tx_full) w_next = ST_TX_NEXT;
            end
            ST_TX_NEXT: begin
                w_tx_data = c_next;
                w_wr      = !i_tx_full;
                if (!i_tx_full) w_next = ST_RX_DUMP;
            end
            ST_RX_DUMP: begin
                w_rd = !i_rx_empty;
                if (w_rd && w_last_byte) w_next = ST_DONE;
                else if (w_to_hit)       w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_ready        <= 1'b0;
            r_in_debug     <= 1'b0;
            r_load_pending <= 1'b0;
            r_size         <= '0;
            r_addr         <= '0;
            r_byte_cnt     <= '0;
            r_kind         <= KIND_REG;
            r_idx          <= '0;
        end else begin
            r_state <= w_next;
            // Registered so that ready is low while reset is applied
            r_ready <= (w_next == ST_IDLE);

            if (w_accept) begin
                r_load_pending <= (i_cmd == CMD_LOAD);
                if (i_cmd == CMD_LOAD) begin
                    r_size     <= i_prog_size;
                    r_addr     <= '0;
                    r_byte_cnt <= '0;
                end
            end

            if (w_wr) begin
                case (r_state)
                    ST_TX_END: r_in_debug <= 1'b0;
                    ST_TX_DBG: r_in_debug <= 1'b1;
                    ST_TX_INST: begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) r_addr <= r_addr + PSZ_W'(1);
                    end
                    default: ;
                endcase
            end

            if (w_to_hit) r_in_debug <= 1'b0;

            // Kind/index describe the word currently being assembled and
            // advance on its strobe, so they line up with o_dump_valid.
            if (r_state == ST_TX_NEXT) begin
                r_kind <= KIND_REG;
                r_idx  <= '0;
            end else if (w_pack_valid) begin
                case (r_kind)
                    KIND_REG: begin
                        if (r_idx == 6'(N_REG - 1)) begin
                            r_kind <= KIND_MEM;
                            r_idx  <= '0;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                    KIND_MEM: begin
                        if (r_idx == 6'(N_MEM - 1)) begin
                            r_kind <= KIND_PC;
                            r_idx  <= '0;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                    default: begin
                        r_kind <= KIND_REG;
                        r_idx  <= '0;
                    end
                endcase
            end
        end
    end

    uart_word_packer u_packer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (r_state == ST_TX_NEXT),
        .i_byte_valid (w_rd),
        .i_byte       (i_rx_data),
        .o_count      (w_pack_cnt),
        .o_word_valid (w_pack_valid),
        .o_word       (w_pack_word)
    );

`ifdef UART_DEBUG_HOST_TIMEOUT_EN
    localparam logic [31:0] c_to_last = 32'(TO_CYC - 1);

    logic [31:0] r_idle_cnt;
    logic        r_timeout;

    assign w_to_hit = (r_state == ST_RX_DUMP) && i_rx_empty && (r_idle_cnt == c_to_last);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            // Counts consecutive empty cycles; any consumed byte restarts it
            if ((r_state != ST_RX_DUMP) || !i_rx_empty) r_idle_cnt <= '0;
            else                                        r_idle_cnt <= r_idle_cnt + 32'd1;
            if (w_to_hit) r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_to_hit  = 1'b0;
    // Watchdog not built; the limit only takes part in a constant-false term
    assign o_timeout = 1'b0 & (TO_CYC > 0);
`endif

    assign o_cmd_ready  = r_ready;
    assign o_prog_addr  = r_addr;
    assign o_tx_data    = w_tx_data;
    assign o_wr         = w_wr;
    assign o_rd         = w_rd;
    assign o_dump_valid = w_pack_valid;
    assign o_dump_kind  = r_kind;
    assign o_dump_idx   = r_idx;
    assign o_dump_word  = w_pack_word;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_in_debug   = r_in_debug;

endmodule

`default_nettype wire

// File: tb/tb_uart_debug_host.sv
// ============================================================================
//  Module   : tb_uart_debug_host
//  Purpose  : Self-checking bench for uart_debug_host. Directed vector table,
//             reset/reserved/timeout sequences and randomized commands
//             compared against a byte-stream model of the protocol.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_debug_host;

`ifdef UART_DEBUG_HOST_TIMEOUT_EN
    localparam int TB_TO = 100;
`else
    localparam int TB_TO = 1000000;
`endif
    localparam int NR = 31;
    localparam int NM = 31;
    localparam int NW = NR + NM + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic [7:0]  prog_size;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic [7:0]  tx_data;
    logic        wr;
    logic        tx_full;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rd;
    logic        dump_valid;
    logic [1:0]  dump_kind;
    logic [5:0]  dump_idx;
    logic [31:0] dump_word;
    logic        busy;
    logic        done;
    logic        in_debug;
    logic        timeout;

    always #5 clk = ~clk;

    uart_debug_host #(.N_REG(NR), .N_MEM(NM), .PSZ_W(8), .TO_CYC(TB_TO)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready),
        .i_prog_size(prog_size), .o_prog_addr(prog_addr), .i_prog_data(prog_data),
        .o_tx_data(tx_data), .o_wr(wr), .i_tx_full(tx_full),
        .i_rx_data(rx_data), .i_rx_empty(rx_empty), .o_rd(rd),
        .o_dump_valid(dump_valid), .o_dump_kind(dump_kind), .o_dump_idx(dump_idx),
        .o_dump_word(dump_word), .o_busy(busy), .o_done(done),
        .o_in_debug(in_debug), .o_timeout(timeout)
    );

    // Program memory with one-cycle synchronous read
    logic [31:0] prog_mem [256];
    always @(posedge clk) prog_data <= prog_mem[prog_addr];

    typedef struct { logic [1:0] kind; logic [5:0] idx; logic [31:0] word; } dump_t;

    int          n_err = 0;
    int          n_checks = 0;
    int          tx_mode = 0;   // 0 never full, 1 toggling, 2 random
    int          rx_mode = 0;   // 0 ready when data, 1 random stall, 2 always empty
    int          done_cnt = 0;
    int          rx_pops = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  addr_q[$];
    logic [7:0]  exp_tx[$];
    dump_t       dump_q[$];
    logic [31:0] dump_words [NW];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // FIFO models: present inputs at the falling edge, observe strobes just after
    initial begin
        bit tog;
        tog = 1'b0;
        tx_full = 1'b0; rx_empty = 1'b1; rx_data = 8'h00;
        forever begin
            @(negedge clk);
            case (tx_mode)
                0:       tx_full = 1'b0;
                1:       begin tog = ~tog; tx_full = tog; end
                default: tx_full = ($urandom_range(0, 2) == 0);
            endcase
            if (rx_q.size() == 0 || rx_mode == 2) rx_empty = 1'b1;
            else if (rx_mode == 1)                rx_empty = ($urandom_range(0, 3) == 0);
            else                                  rx_empty = 1'b0;
            rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
            #1;
            if (!rst) begin
                if (wr) begin
                    chk("wr_while_full", {31'd0, tx_full}, 32'd0);
                    tx_q.push_back(tx_data);
                    addr_q.push_back(prog_addr);
                end
                if (rd) begin
                    chk("rd_while_empty", {31'd0, rx_empty}, 32'd0);
                    if (rx_q.size() != 0) begin
                        void'(rx_q.pop_front());
                        rx_pops++;
                    end
                end
                if (dump_valid) dump_q.push_back('{dump_kind, dump_idx, dump_word});
                if (done) done_cnt++;
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] sz);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd = c; prog_size = sz;
        for (int t = 0; t < 50 && !acc; t++) begin
            #2;
            if (cmd_ready) acc = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!acc) chk("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic preload_rx();
        rx_q.delete();
        for (int k = 0; k < NW; k++)
            for (int b = 0; b < 4; b++)
                rx_q.push_back(dump_words[k][8*b +: 8]);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] c, input logic [7:0] sz,
                           input int txm, input int rxm, input bit pre);
        int start;
        tx_mode = txm; rx_mode = rxm;
        tx_q.delete(); addr_q.delete(); dump_q.delete();
        if (pre) preload_rx();
        start = done_cnt;
        issue(c, sz);
        for (int t = 0; t < 4000 && done_cnt == start; t++) begin
            @(negedge clk); #2;
        end
        repeat (2) @(negedge clk);
        #2;
        chk($sformatf("%s_done_once", tag), done_cnt - start, 32'd1);
    endtask

    // Expected dump layout: NR register words, NM memory words, then PC
    task automatic check_result(input string tag, input logic exp_dbg, input int ndump);
        logic [1:0] ek;
        logic [5:0] ei;
        chk($sformatf("%s_txlen", tag), tx_q.size(), exp_tx.size());
        for (int j = 0; j < exp_tx.size(); j++)
            chk($sformatf("%s_txb%0d", tag, j),
                (j < tx_q.size()) ? {24'd0, tx_q[j]} : 32'hDEAD_BEEF, {24'd0, exp_tx[j]});
        chk($sformatf("%s_ndump", tag), dump_q.size(), ndump);
        for (int k = 0; k < ndump; k++) begin
            if (k < NR)           begin ek = 2'd0; ei = 6'(k);      end
            else if (k < NR + NM) begin ek = 2'd1; ei = 6'(k - NR); end
            else                  begin ek = 2'd2; ei = 6'd0;       end
            if (k < dump_q.size()) begin
                chk($sformatf("%s_dkind%0d", tag, k), {dump_q[k].kind, dump_q[k].idx}, {ek, ei});
                chk($sformatf("%s_dword%0d", tag, k), dump_q[k].word, dump_words[k]);
            end
        end
        chk($sformatf("%s_in_debug", tag), {31'd0, in_debug}, {31'd0, exp_dbg});
        chk($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [7:0]  size;
        int          txm;
        int          rxm;
        int          ntx;
        logic [95:0] txb;
        logic        dbg;
        int          ndump;
    } vec_t;

    vec_t vt [9];

    initial begin
        bit         m_dbg;
        int         nd;
        int         cyc;
        int         start;
        logic [1:0] c;
        logic [7:0] sz;

        vt[0] = '{2'd0, 8'd2, 0, 0, 10, 96'hFE02_4433_2211_DDCC_BBAA_0000, 1'b0, 0};
        vt[1] = '{2'd0, 8'd1, 1, 0,  6, 96'hFE01_4433_2211_0000_0000_0000, 1'b0, 0};
        vt[2] = '{2'd0, 8'd0, 2, 0,  2, 96'hFE00_0000_0000_0000_0000_0000, 1'b0, 0};
        vt[3] = '{2'd1, 8'd0, 0, 0,  2, 96'hFC01_0000_0000_0000_0000_0000, 1'b1, NW};
        vt[4] = '{2'd1, 8'd0, 2, 1,  1, 96'h0100_0000_0000_0000_0000_0000, 1'b1, NW};
        vt[5] = '{2'd2, 8'd0, 0, 0,  1, 96'hF800_0000_0000_0000_0000_0000, 1'b0, 0};
        vt[6] = '{2'd2, 8'd0, 1, 0,  0, 96'h0,                             1'b0, 0};
        vt[7] = '{2'd1, 8'd0, 1, 1,  2, 96'hFC01_0000_0000_0000_0000_0000, 1'b1, NW};
        vt[8] = '{2'd0, 8'd1, 2, 0,  7, 96'hF8FE_0144_3322_1100_0000_0000, 1'b0, 0};

        for (int k = 0; k < 256; k++) prog_mem[k] = 32'h0;
        prog_mem[0] = 32'h1122_3344;
        prog_mem[1] = 32'hAABB_CCDD;
        for (int k = 0; k < NW; k++) dump_words[k] = 32'(k);

        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; prog_size = 8'd0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outs", {cmd_ready, prog_addr, tx_data, wr, rd, dump_valid, dump_kind,
                           dump_idx, busy, done, in_debug, timeout}, 32'd0);
        chk("reset_word", dump_word, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 9; i++) begin
            exp_tx.delete();
            for (int j = 0; j < vt[i].ntx; j++) exp_tx.push_back(vt[i].txb[95-8*j -: 8]);
            run_cmd($sformatf("vec%0d", i), vt[i].cmd, vt[i].size, vt[i].txm, vt[i].rxm, vt[i].cmd == 2'd1);
            check_result($sformatf("vec%0d", i), vt[i].dbg, vt[i].ndump);
            if (i == 0) begin
                chk("vec0_addr_w0", (addr_q.size() > 2) ? addr_q[2] : 8'hFF, 32'd0);
                chk("vec0_addr_w1", (addr_q.size() > 6) ? addr_q[6] : 8'hFF, 32'd1);
            end
        end
        m_dbg = 1'b0;

        // ---------------- reserved command is ignored ----------------
        tx_q.delete();
        start = done_cnt;
        issue(2'd3, 8'd0);
        repeat (5) @(negedge clk);
        #2;
        chk("rsvd_no_done", done_cnt - start, 32'd0);
        chk("rsvd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rsvd_no_tx", tx_q.size(), 32'd0);

        // ---------------- async reset mid-dump ----------------
        tx_mode = 0; rx_mode = 0;
        preload_rx();
        rx_pops = 0;
        issue(2'd1, 8'd0);
        for (int t = 0; t < 2000 && rx_pops < 5; t++) begin
            @(negedge clk); #2;
        end
        chk("rst_mid_pops", rx_pops, 32'd5);
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", {cmd_ready, prog_addr, tx_data, wr, rd, dump_valid, dump_kind,
                             dump_idx, busy, done, in_debug, timeout}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        repeat (2) @(negedge clk);
        exp_tx.delete();
        exp_tx.push_back(8'hFC); exp_tx.push_back(8'h01);
        run_cmd("post_rst", 2'd1, 8'd0, 0, 0, 1'b1);
        check_result("post_rst", 1'b1, NW);
        exp_tx.delete();
        exp_tx.push_back(8'hF8);
        run_cmd("post_rst_end", 2'd2, 8'd0, 0, 0, 1'b0);
        check_result("post_rst_end", 1'b0, 0);

        // ---------------- randomized commands vs. protocol model ----------------
        for (int it = 0; it < 8; it++) begin
            c  = 2'($urandom_range(0, 2));
            sz = 8'($urandom_range(0, 4));
            for (int k = 0; k < 5; k++) prog_mem[k] = $urandom;
            for (int k = 0; k < NW; k++) dump_words[k] = $urandom;
            exp_tx.delete();
            nd = 0;
            case (c)
                2'd0: begin
                    if (m_dbg) begin exp_tx.push_back(8'hF8); m_dbg = 1'b0; end
                    exp_tx.push_back(8'hFE);
                    exp_tx.push_back(sz);
                    for (int w = 0; w < int'(sz); w++)
                        for (int b = 0; b < 4; b++) exp_tx.push_back(prog_mem[w][8*b +: 8]);
                end
                2'd1: begin
                    if (!m_dbg) exp_tx.push_back(8'hFC);
                    m_dbg = 1'b1;
                    exp_tx.push_back(8'h01);
                    nd = NW;
                end
                default: begin
                    if (m_dbg) exp_tx.push_back(8'hF8);
                    m_dbg = 1'b0;
                end
            endcase
            run_cmd($sformatf("rnd%0d", it), c, sz, $urandom_range(0, 2), $urandom_range(0, 1), c == 2'd1);
            check_result($sformatf("rnd%0d", it), m_dbg, nd);
        end

        // ---------------- RX-idle watchdog ----------------
`ifdef UART_DEBUG_HOST_TIMEOUT_EN
        if (m_dbg) begin
            exp_tx.delete();
            exp_tx.push_back(8'hF8);
            run_cmd("to_close", 2'd2, 8'd0, 0, 0, 1'b0);
            check_result("to_close", 1'b0, 0);
        end
        tx_mode = 0; rx_mode = 2;
        rx_q.delete(); tx_q.delete(); dump_q.delete();
        start = done_cnt;
        cyc = 0;
        issue(2'd1, 8'd0);
        for (int t = 0; t < 400 && done_cnt == start; t++) begin
            @(negedge clk); #2;
            cyc++;
        end
        chk("to_cycles_in_range", {31'd0, (cyc >= 100 && cyc <= 110)}, 32'd1);
        chk("to_done", done_cnt - start, 32'd1);
        chk("to_flag", {31'd0, timeout}, 32'd1);
        chk("to_in_debug", {31'd0, in_debug}, 32'd0);
        chk("to_tx_len", tx_q.size(), 32'd2);
        chk("to_no_dump", dump_q.size(), 32'd0);
        exp_tx.delete();
        run_cmd("to_sticky", 2'd2, 8'd0, 0, 0, 1'b0);
        chk("to_flag_sticky", {31'd0, timeout}, 32'd1);
`else
        cyc = 0;
        start = 0;
        chk("timeout_tied_low", {31'd0, timeout}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire

// File: doc/uart_debug_host.md
Name: uart_debug_host

Overview:
- Host-side partner of the pipeline's UART debug interface.
- Drives the command byte protocol into a UART TX FIFO: program load, debug entry, single step, end debug.
- Drains the state dump returned through the UART RX FIFO: register words, data-memory words, then PC. Reassembles each dump as 32-bit words.
- Used as an on-chip loader/debug master and as a loop-back verification partner.

Parameters:
- N_REG, 31, register words per dump.
- N_MEM, 31, data-memory words per dump.
- PSZ_W, 8, program-size / program-address width.
- TO_CYC, 1000000, RX-idle watchdog limit in cycles (optional feature only).

Ports:
- i_clock  in  1  clock
- i_reset  in  1  async active-high reset
- i_cmd_valid  in  1  command request
- i_cmd  in  2  0=LOAD, 1=STEP, 2=END, 3=reserved (ignored, ready stays high)
- o_cmd_ready  out  1  high only in IDLE
- i_prog_size  in  PSZ_W  instruction count, sampled at LOAD acceptance
- o_prog_addr  out  PSZ_W  program source word address
- i_prog_data  in  32  program word; synchronous read, valid 1 cycle after o_prog_addr changes
- o_tx_data  out  8  byte to TX FIFO
- o_wr  out  1  TX FIFO write strobe
- i_tx_full  in  1  TX FIFO full
- i_rx_data  in  8  RX FIFO head byte (first-word fall-through)
- i_rx_empty  in  1  RX FIFO empty
- o_rd  out  1  RX FIFO pop
- o_dump_valid  out  1  one-cycle word strobe
- o_dump_kind  out  2  0=REG, 1=MEM, 2=PC
- o_dump_idx  out  6  word index within kind
- o_dump_word  out  32  assembled word
- o_busy  out  1  not IDLE
- o_done  out  1  one-cycle pulse on command completion
- o_in_debug  out  1  debug session open
- o_timeout  out  1  sticky watchdog flag (0 when feature out)

Behaviour:
- Byte codes (package): LOAD_PROG_SIZE=0xFE, DEBUG=0xFC, NEXT=0x01, END_DEBUG=0xF8.
- Reset values: all outputs 0; FSM IDLE; session flag cleared.
- Handshake: command accepted on the cycle i_cmd_valid && o_cmd_ready.
- Byte write: o_wr=1 only when !i_tx_full. Each write advances the byte sequence. While full, hold o_tx_data and state.
- Byte read: o_rd=1 only when !i_rx_empty. A byte is consumed on that cycle.
- States: IDLE, TX_OP, TX_SIZE, FETCH, TX_INST, TX_DBG, TX_NEXT, RX_DUMP, TX_END, DONE.
- LOAD:
  - TX_OP sends 0xFE; TX_SIZE sends i_prog_size.
  - Per word: FETCH (1 cycle, address held), then TX_INST sends 4 bytes LSB first (2-bit byte counter). o_prog_addr increments after byte 3.
  - After word size-1, go to DONE.
  - Size 0: send 0xFE, 0x00, no FETCH, go to DONE.
  - LOAD while o_in_debug=1: sends END_DEBUG first, clears the session, then proceeds.
- STEP:
  - If !o_in_debug: TX_DBG sends 0xFC and sets o_in_debug.
  - TX_NEXT sends 0x01.
  - RX_DUMP consumes 4*(N_REG+N_MEM+1) bytes LSB-first. A 2-bit byte counter and 32-bit shift assembler build each word.
  - On each 4th byte: o_dump_valid pulses the next cycle with kind/index. Index resets to 0 at each kind change.
  - After the PC word, go to DONE.
- END: if o_in_debug, TX_END sends 0xF8 and clears the session; else go straight to DONE. Then DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Simultaneous i_tx_full and i_rx_empty transitions are independent; no byte is lost or duplicated.
- Async reset mid-operation returns to IDLE immediately, discarding partial words. FIFOs are not flushed by this block.

Optional Feature:
- Macro: UART_DEBUG_HOST_TIMEOUT_EN.
- With it: a cycle counter runs in RX_DUMP while i_rx_empty, cleared on each consumed byte. Reaching TO_CYC sets o_timeout (sticky until reset), clears o_in_debug, and goes to DONE.
- Without it: RX_DUMP waits indefinitely and o_timeout is tied 0.

Decomposition:
- Package uart_dbg_pkg: byte code constants, command enum (LOAD/STEP/END), dump-kind enum, state encoding.
- One sub-module: uart_word_packer, a 4-byte LSB-first byte→word assembler with count, shared for RX dump reassembly.

Test Plan:
- LOAD, size=2, words 0x11223344 and 0xAABBCCDD, TX never full -> TX bytes FE 02 44 33 22 11 DD CC BB AA; o_done once; o_prog_addr reads 0 then 1.
- LOAD, size=1, with i_tx_full toggled every other cycle -> same byte order (FE 01 + 4 bytes); no duplicated or dropped writes.
- STEP from IDLE with no session, RX preloaded with 252 bytes where word k = k -> TX FC 01; 31 REG words 0..30, 31 MEM words 31..61, PC=62; o_in_debug=1.
- Second STEP -> TX only 01; dump received again; END -> TX F8; o_in_debug=0.
- Reset asserted after 5 dump bytes -> all outputs 0 and IDLE next edge; a following STEP resends FC 01.
- Feature on, TO_CYC=100, STEP with RX empty -> after 100 idle cycles o_timeout=1, o_done pulse, o_in_debug=0.
